// File: rtl/vector_mem_access_pkg.sv
// Shared types, geometry and lane helper for the vector memory access unit.
// The geometry lives here so the interface, the helper and the unit agree on widths.
package vector_mem_pkg;

   localparam int DATA_WIDTH  = 8;
   localparam int VECTOR_SIZE = 6;
   localparam int ADDR_WIDTH  = 16;
   localparam int VEC_WIDTH   = DATA_WIDTH * VECTOR_SIZE;
   localparam int LANE_W      = $clog2(VECTOR_SIZE);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      DONE
   } vmem_state_t;

   // Picks one DATA_WIDTH lane out of a packed vector; lane 0 sits in the low bits.
   function automatic logic [DATA_WIDTH-1:0] lane_slice(input logic [VEC_WIDTH-1:0] vector,
                                                        input logic [LANE_W-1:0]    index);
      return vector[DATA_WIDTH*index +: DATA_WIDTH];
   endfunction

endpackage

// File: rtl/vector_mem_access_if.sv
// Pipeline-side request/response signals and data-memory port of the access unit.
// The slave modport is the unit itself; the master modport is whoever drives requests and owns the RAM.
interface vector_mem_access_if;
   import vector_mem_pkg::*;

   logic                  start;
   logic                  isWrite;
   logic                  isVector;
   logic [ADDR_WIDTH-1:0] address;
   logic [VEC_WIDTH-1:0]  writeData;
   logic                  stall;
   logic                  busy;
   logic                  done;
   logic [VEC_WIDTH-1:0]  readData;
   logic [ADDR_WIDTH-1:0] memAddr;
   logic [DATA_WIDTH-1:0] memWriteData;
   logic                  memWriteEnable;
   logic [DATA_WIDTH-1:0] memReadData;

   modport slave (
      input  start, isWrite, isVector, address, writeData, memReadData,
      output stall, busy, done, readData, memAddr, memWriteData, memWriteEnable
   );

   modport master (
      output start, isWrite, isVector, address, writeData, memReadData,
      input  stall, busy, done, readData, memAddr, memWriteData, memWriteEnable
   );

endinterface

// File: rtl/vector_mem_access.sv
// Memory-stage access unit: serialises scalar/vector loads and stores onto a
// one-lane-wide synchronous data memory and stalls the pipeline while busy.
module vector_mem_access
   import vector_mem_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   vector_mem_access_if.slave  bus
);

   vmem_state_t           stateQ, stateD;
   logic [LANE_W-1:0]     laneQ, laneD;
   logic [LANE_W-1:0]     lastLaneQ, lastLaneD;
   logic [ADDR_WIDTH-1:0] baseQ, baseD;
   logic [VEC_WIDTH-1:0]  writeDataQ, writeDataD;
   logic [VEC_WIDTH-1:0]  readDataQ, readDataD;

   logic [LANE_W-1:0]     prevLane;
   logic [ADDR_WIDTH-1:0] laneAddr;
   logic                  busyInt;

   // The RAM returns data one cycle late, so a READ capture always targets the previous lane.
   assign prevLane = laneQ - LANE_W'(1);
   assign laneAddr = baseQ + ADDR_WIDTH'(laneQ);
   assign busyInt  = (stateQ != IDLE);

   // State register; reset forces IDLE even in the middle of an access.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stateQ <= IDLE;
      end else begin
         stateQ <= stateD;
      end
   end

   // Next-state: accept only in IDLE, walk the lanes, drain the last read, pulse DONE once.
   always_comb begin
      stateD = stateQ;
      case (stateQ)
         IDLE:    if (bus.start) stateD = bus.isWrite ? WRITE : READ;
         WRITE:   if (laneQ == lastLaneQ) stateD = DONE;
         READ:    if (laneQ == lastLaneQ) stateD = DRAIN;
         DRAIN:   stateD = DONE;
         DONE:    stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   // Datapath next values: latch the request on accept, advance the lane, capture load lanes.
   always_comb begin
      laneD      = laneQ;
      lastLaneD  = lastLaneQ;
      baseD      = baseQ;
      writeDataD = writeDataQ;
      readDataD  = readDataQ;
      case (stateQ)
         IDLE: begin
            if (bus.start) begin
               laneD      = '0;
               lastLaneD  = bus.isVector ? LANE_W'(VECTOR_SIZE - 1) : '0;
               baseD      = bus.address;
               writeDataD = bus.writeData;
               if (!bus.isWrite) readDataD = '0;
            end
         end
         WRITE: begin
            if (laneQ != lastLaneQ) laneD = laneQ + LANE_W'(1);
         end
         READ: begin
            if (laneQ != '0) readDataD[DATA_WIDTH*prevLane +: DATA_WIDTH] = bus.memReadData;
            if (laneQ != lastLaneQ) laneD = laneQ + LANE_W'(1);
         end
         DRAIN: begin
            readDataD[DATA_WIDTH*lastLaneQ +: DATA_WIDTH] = bus.memReadData;
         end
         default: ;
      endcase
   end

   // Datapath registers; a reset discards any partially gathered load data.
   always_ff @(posedge clk) begin
      if (!reset) begin
         laneQ      <= '0;
         lastLaneQ  <= '0;
         baseQ      <= '0;
         writeDataQ <= '0;
         readDataQ  <= '0;
      end else begin
         laneQ      <= laneD;
         lastLaneQ  <= lastLaneD;
         baseQ      <= baseD;
         writeDataQ <= writeDataD;
         readDataQ  <= readDataD;
      end
   end

   // Outputs: the memory port is quiet except while walking lanes; only WRITE strobes the RAM.
   always_comb begin
      bus.memAddr        = '0;
      bus.memWriteData   = '0;
      bus.memWriteEnable = 1'b0;
      case (stateQ)
         WRITE: begin
            bus.memAddr        = laneAddr;
            bus.memWriteData   = lane_slice(writeDataQ, laneQ);
            bus.memWriteEnable = 1'b1;
         end
         READ, DRAIN: begin
            bus.memAddr = laneAddr;
         end
         default: ;
      endcase
      bus.busy     = busyInt;
      bus.done     = (stateQ == DONE);
      bus.stall    = busyInt | (bus.start & (stateQ == IDLE));
      bus.readData = readDataQ;
   end

endmodule

// File: tb/tb_vector_mem_access.sv
// Directed bench for vector_mem_access: a behavioural synchronous RAM plus
// hand-computed expectations for stores, loads, wrap-around, ignored starts and reset.
module tb_vector_mem_access;
   import vector_mem_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   doneCount = 0;
   int   lat;
   int   doneBefore;
   bit   stallOk;
   logic [7:0]  mem [0:65535];
   logic [15:0] wrAddr [$];
   logic [7:0]  wrData [$];
   int          wrCyc  [$];

   vector_mem_access_if bus();

   vector_mem_access dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: write on strobe, read data appears the cycle after the address.
   always @(posedge clk) begin
      if (bus.memWriteEnable) mem[bus.memAddr] <= bus.memWriteData;
      bus.memReadData <= mem[bus.memAddr];
   end

   // Logs every write strobe with its cycle number and counts done pulses.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.memWriteEnable) begin
         wrAddr.push_back(bus.memAddr);
         wrData.push_back(bus.memWriteData);
         wrCyc.push_back(cyc);
      end
      if (bus.done) doneCount <= doneCount + 1;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic clearLog();
      wrAddr.delete();
      wrData.delete();
      wrCyc.delete();
   endtask

   // Issues one request from an IDLE cycle and reports cycles from accept to done.
   task automatic applyStimulus(input logic wr, input logic vec, input logic [15:0] addr,
                                input logic [47:0] data, output int latency, output bit stallHigh);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.isWrite   = wr;
      bus.isVector  = vec;
      bus.address   = addr;
      bus.writeData = data;
      #1;
      checkOutput("stallAtStart", bus.stall, 1);
      @(negedge clk);
      bus.start = 1'b0;
      latency   = 0;
      stallHigh = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         stallHigh &= bus.stall;
         if (bus.done) begin
            latency = c;
            break;
         end
         @(negedge clk);
      end
      if (latency == 0) checkOutput("doneTimeout", 0, 1);
   endtask

   task automatic expectWrites(input string tag, input logic [15:0] base, input logic [47:0] data, input int n);
      logic [15:0] a;
      checkOutput({tag, "Count"}, wrAddr.size(), n);
      for (int i = 0; i < n && i < wrAddr.size(); i++) begin
         a = base + 16'(i);
         checkOutput($sformatf("%sAddr%0d", tag, i), wrAddr[i], a);
         checkOutput($sformatf("%sData%0d", tag, i), wrData[i], data[8*i +: 8]);
      end
      if (wrAddr.size() == n && n > 0)
         checkOutput({tag, "Consecutive"}, wrCyc[n-1] - wrCyc[0], n - 1);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      for (int i = 0; i < 6; i++) mem[16'h0020 + i] = 8'hA0 + 8'(i);
      mem[16'h0030] = 8'h7F;
      bus.start       = 1'b0;
      bus.isWrite     = 1'b0;
      bus.isVector    = 1'b0;
      bus.address     = '0;
      bus.writeData   = '0;
      bus.memReadData = '0;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rstBusy", bus.busy, 0);
      checkOutput("rstDone", bus.done, 0);
      checkOutput("rstWe", bus.memWriteEnable, 0);
      checkOutput("rstAddr", bus.memAddr, 0);
      checkOutput("rstWData", bus.memWriteData, 0);
      checkOutput("rstRData", bus.readData, 0);
      checkOutput("rstStall", bus.stall, 0);

      // Reset and start together: reset wins
      bus.start = 1'b1; bus.isWrite = 1'b1; bus.isVector = 1'b1; bus.address = 16'h0055;
      @(negedge clk);
      checkOutput("rstStartBusy", bus.busy, 0);
      checkOutput("rstStartWe", bus.memWriteEnable, 0);
      bus.start = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("idleBusy", bus.busy, 0);

      // Vector store at 0x0010
      clearLog();
      applyStimulus(1'b1, 1'b1, 16'h0010, 48'h665544332211, lat, stallOk);
      checkOutput("vstLatency", lat, 7);
      checkOutput("vstStall", stallOk, 1);
      expectWrites("vst", 16'h0010, 48'h665544332211, 6);

      // Vector load from 0x0020
      clearLog();
      applyStimulus(1'b0, 1'b1, 16'h0020, 48'h0, lat, stallOk);
      checkOutput("vldLatency", lat, 8);
      checkOutput("vldData", bus.readData, 48'hA5A4A3A2A1A0);
      checkOutput("vldNoWrites", wrAddr.size(), 0);

      // Scalar load from 0x0030 clears the upper lanes
      applyStimulus(1'b0, 1'b0, 16'h0030, 48'h0, lat, stallOk);
      checkOutput("sldLatency", lat, 3);
      checkOutput("sldData", bus.readData, 48'h00000000007F);

      // Vector store wrapping past 0xFFFF
      clearLog();
      applyStimulus(1'b1, 1'b1, 16'hFFFE, 48'h060504030201, lat, stallOk);
      checkOutput("wrapLatency", lat, 7);
      expectWrites("wrap", 16'hFFFE, 48'h060504030201, 6);
      if (wrAddr.size() == 6) begin
         checkOutput("wrapAddr2", wrAddr[2], 16'h0000);
         checkOutput("wrapAddr5", wrAddr[5], 16'h0003);
      end
      checkOutput("rdHeldAfterStore", bus.readData, 48'h00000000007F);

      // start held high through a busy store with changed request fields
      clearLog();
      @(negedge clk);
      bus.start = 1'b1; bus.isWrite = 1'b1; bus.isVector = 1'b1;
      bus.address = 16'h0040; bus.writeData = 48'hD5D4D3D2D1D0;
      @(negedge clk);
      bus.address = 16'h0080; bus.writeData = 48'hEEEEEEEEEEEE;
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         if (bus.done) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
      checkOutput("holdLatency", lat, 7);
      expectWrites("hold", 16'h0040, 48'hD5D4D3D2D1D0, 6);
      @(negedge clk);
      checkOutput("holdIdleBusy", bus.busy, 0);
      checkOutput("holdIdleStall", bus.stall, 1);
      clearLog();
      @(negedge clk);
      checkOutput("holdAcceptBusy", bus.busy, 1);
      checkOutput("holdAcceptAddr", bus.memAddr, 16'h0080);
      bus.start = 1'b0;
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         if (bus.done) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
      checkOutput("secondDone", lat, 7);
      expectWrites("second", 16'h0080, 48'hEEEEEEEEEEEE, 6);

      // Reset after the third write of a vector store
      @(negedge clk);
      doneBefore = doneCount;
      clearLog();
      bus.start = 1'b1; bus.isWrite = 1'b1; bus.isVector = 1'b1;
      bus.address = 16'h0090; bus.writeData = 48'h1F1E1D1C1B1A;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("abortThirdAddr", bus.memAddr, 16'h0092);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("abortBusy", bus.busy, 0);
      checkOutput("abortWe", bus.memWriteEnable, 0);
      checkOutput("abortAddr", bus.memAddr, 0);
      checkOutput("abortWData", bus.memWriteData, 0);
      checkOutput("abortRData", bus.readData, 0);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("abortNoDone", doneCount, doneBefore);
      checkOutput("abortWrites", wrAddr.size(), 3);
      checkOutput("abortMem92", mem[16'h0092], 8'h1C);
      checkOutput("abortMem93", mem[16'h0093], 8'h00);
      checkOutput("abortIdleBusy", bus.busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog so a stuck design still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
